serial_tx: RTL

Parallel-to-serial transmit stage for the serial system bus. It sits directly downstream of the transmit byte FIFO. Whenever the FIFO is non-empty and transmission is enabled, it pops one word and drives it onto the single-wire serial line as a framed word: start bit, data LSB first, even parity, stop bit.

---
 rtl/serial_bus_pkg.sv | 23 ++
 rtl/bit_timer.sv | 36 +++
 rtl/serial_tx.sv | 105 ++++++++++
 3 files changed

// File: rtl/serial_bus_pkg.sv
//============================================================================
// Module   : serial_bus_pkg
// Shared encodings and line-level constants for the serial system bus.
// Revision : 1.0
//============================================================================
`default_nettype none

package serial_bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam int   FRAME_OVERHEAD_BITS = 3;
    localparam logic IDLE_LEVEL          = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bit_timer.sv
//============================================================================
// Module   : bit_timer
// Free-running bit-period counter; tick marks the last cycle of each period.
// Revision : 1.0
//============================================================================
`default_nettype none

module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] cnt_q;

    // Wrapping on tick doubles as the clear on every state entry after START.
    always_ff @(posedge clk) begin
        if (!rstn || clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + c_ONE;
        end
    end

    assign tick = (cnt_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/serial_tx.sv
//============================================================================
// Module   : serial_tx
// Framed parallel-to-serial transmitter: start, LSB-first data, even parity, stop.
// Revision : 1.0
//============================================================================
`default_nettype none

module serial_tx
    import serial_bus_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_deq,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int               c_IDX_W    = $clog2(DATA_WIDTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  parity_q;
    logic [c_IDX_W-1:0]    bit_idx_q;
    logic                  tx_q;
    logic                  frame_done_q;
    logic                  tick;
    logic                  start;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk (clk),
        .rstn(rstn),
        .clr (state_q == IDLE),
        .tick(tick)
    );

    // A new frame may begin in the last stop cycle so back-to-back frames have no gap.
    assign start = rstn & en & ~fifo_empty &
                   ((state_q == IDLE) | ((state_q == STOP) & tick));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            bit_idx_q    <= '0;
            tx_q         <= IDLE_LEVEL;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= (state_q == STOP) && tick;
            if (start) begin
                shift_q   <= fifo_data;
                parity_q  <= ^fifo_data;
                bit_idx_q <= '0;
                state_q   <= START;
                tx_q      <= 1'b0;
            end else begin
                case (state_q)
                    START: if (tick) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                    DATA: if (tick) begin
                        if (bit_idx_q == c_LAST_IDX) begin
                            state_q <= PARITY;
                            tx_q    <= parity_q;
                        end else begin
                            bit_idx_q <= bit_idx_q + c_IDX_ONE;
                            shift_q   <= {1'b0, shift_q[DATA_WIDTH-1:1]};
                            tx_q      <= shift_q[1];
                        end
                    end
                    PARITY: if (tick) begin
                        state_q <= STOP;
                        tx_q    <= IDLE_LEVEL;
                    end
                    STOP: if (tick) begin
                        state_q <= IDLE;
                    end
                    IDLE: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign fifo_deq   = start;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire
